// File: rtl/palette_decode.sv
// Inverse palette search: recovers the iteration count behind an RGB888 pixel.
// Tests LANES candidate counts per cycle with valid/ready on both sides.
module palette_decode #(
  parameter int LANES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_rgb,
  input  logic [1:0]  in_mode,
  input  logic [7:0]  in_max_iter,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_iter,
  output logic        out_hit,
  output logic        out_black
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t      state_q, state_d;
  logic [8:0]  cand_q, cand_d;
  logic [23:0] rgb_q, rgb_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  max_q, max_d;
  logic [7:0]  iter_q, iter_d;
  logic        hit_q, hit_d;
  logic        black_q, black_d;

  logic        match_any;
  logic [7:0]  match_iter;
  logic [8:0]  lane;
  logic        last;

  function automatic logic [23:0] pal(
    input logic [1:0] m,
    input logic [7:0] i
  );
    logic [7:0] r, g, b;
    r = '0;
    g = '0;
    b = '0;
    unique case (m)
      2'd0: begin
        r = i * 8'd5;
        g = i * 8'd13;
        b = i * 8'd29;
      end
      2'd1: begin
        r = i * 8'd9;
        g = i * 8'd3;
        b = i * 8'd17;
      end
      2'd2: begin
        r = {i[5:0], 2'b00};
        g = {i[6:0], 1'b0};
        b = i * 8'd11;
      end
      2'd3: begin
        r = i * 8'd7;
        g = i * 8'd21;
        b = {i[5:0], 2'b00};
      end
    endcase
    return {r, g, b};
  endfunction

  // Scan lanes high to low so the lowest matching candidate wins.
  always_comb begin
    match_any  = 1'b0;
    match_iter = '0;
    lane       = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      lane = cand_q + 9'(l);
      if (lane < {1'b0, max_q} &&
          pal(mode_q, lane[7:0]) == rgb_q) begin
        match_any  = 1'b1;
        match_iter = lane[7:0];
      end
    end
  end

  assign last = (cand_q + 9'(LANES)) >= {1'b0, max_q};

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    rgb_d   = rgb_q;
    mode_d  = mode_q;
    max_d   = max_q;
    iter_d  = iter_q;
    hit_d   = hit_q;
    black_d = black_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          rgb_d   = in_rgb;
          mode_d  = in_mode;
          max_d   = in_max_iter;
          cand_d  = '0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (rgb_q == 24'd0) begin
          iter_d  = '0;
          hit_d   = 1'b1;
          black_d = 1'b1;
          state_d = DONE;
        end else if (match_any) begin
          iter_d  = match_iter;
          hit_d   = 1'b1;
          black_d = 1'b0;
          state_d = DONE;
        end else if (last) begin
          iter_d  = max_q;
          hit_d   = 1'b0;
          black_d = 1'b0;
          state_d = DONE;
        end else begin
          cand_d = cand_q + 9'(LANES);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= '0;
      rgb_q   <= '0;
      mode_q  <= '0;
      max_q   <= '0;
      iter_q  <= '0;
      hit_q   <= 1'b0;
      black_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      rgb_q   <= rgb_d;
      mode_q  <= mode_d;
      max_q   <= max_d;
      iter_q  <= iter_d;
      hit_q   <= hit_d;
      black_q <= black_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_iter  = iter_q;
  assign out_hit   = hit_q;
  assign out_black = black_q;

endmodule

// File: tb/tb_palette_decode.sv
// Bench for palette_decode: 1-lane and 4-lane instances share one request
// stream; results and latencies come from a table and an arithmetic model.
module tb_palette_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] in_rgb = '0;
  logic [1:0]  in_mode = '0;
  logic [7:0]  in_max_iter = '0;
  logic        out_ready = 1'b0;

  logic        rdy1, val1, hit1, blk1;
  logic [7:0]  it1;
  logic        rdy4, val4, hit4, blk4;
  logic [7:0]  it4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  palette_decode #(.LANES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy1),
    .in_rgb(in_rgb), .in_mode(in_mode),
    .in_max_iter(in_max_iter),
    .out_valid(val1), .out_ready(out_ready),
    .out_iter(it1), .out_hit(hit1),
    .out_black(blk1)
  );

  palette_decode #(.LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy4),
    .in_rgb(in_rgb), .in_mode(in_mode),
    .in_max_iter(in_max_iter),
    .out_valid(val4), .out_ready(out_ready),
    .out_iter(it4), .out_hit(hit4),
    .out_black(blk4)
  );

  typedef struct {
    logic [23:0] rgb;
    logic [1:0]  mode;
    logic [7:0]  mx;
    logic [7:0]  it;
    logic        hit;
    logic        blk;
    int          lat1;
    int          lat4;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference: brute-force search over the palette formulas.
  task automatic model(input logic [23:0] rgb,
                       input logic [1:0] m,
                       input logic [7:0] mx,
                       output logic [7:0] it,
                       output logic hit,
                       output logic blk,
                       output int lat1,
                       output int lat4);
    int mul[4][3];
    int k;
    mul[0] = '{5, 13, 29};
    mul[1] = '{9, 3, 17};
    mul[2] = '{4, 2, 11};
    mul[3] = '{7, 21, 4};
    k = -1;
    for (int i = int'(mx) - 1; i >= 0; i--) begin
      if ((i * mul[m][0]) % 256 == int'(rgb[23:16]) &&
          (i * mul[m][1]) % 256 == int'(rgb[15:8]) &&
          (i * mul[m][2]) % 256 == int'(rgb[7:0]))
        k = i;
    end
    if (rgb == 24'd0) begin
      it = 0; hit = 1; blk = 1;
      lat1 = 1; lat4 = 1;
    end else if (k >= 0) begin
      it = 8'(k); hit = 1; blk = 0;
      lat1 = 1 + k;
      lat4 = 1 + k / 4;
    end else begin
      it = mx; hit = 0; blk = 0;
      lat1 = (mx == 0) ? 1 : int'(mx);
      lat4 = (mx == 0) ? 1 : (int'(mx) + 3) / 4;
    end
  endtask

  task automatic run_req(input string tag,
                         input logic [23:0] rgb,
                         input logic [1:0] m,
                         input logic [7:0] mx,
                         input logic [7:0] eit,
                         input logic ehit,
                         input logic eblk,
                         input int l1,
                         input int l4,
                         input int hold);
    int s1, s4;
    logic [9:0] snap1, snap4;
    @(negedge clk);
    chk({tag, ".in_ready1"}, 32'(rdy1), 1);
    chk({tag, ".in_ready4"}, 32'(rdy4), 1);
    in_rgb = rgb;
    in_mode = m;
    in_max_iter = mx;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_rgb = $urandom;
    in_max_iter = $urandom;
    s1 = 0;
    s4 = 0;
    for (int e = 1; e <= 300; e++) begin
      @(posedge clk);
      #1;
      if (val1 && s1 == 0) s1 = e;
      if (val4 && s4 == 0) s4 = e;
      if (s1 != 0 && s4 != 0) break;
    end
    chk({tag, ".lat1"}, 32'(s1), 32'(l1));
    chk({tag, ".lat4"}, 32'(s4), 32'(l4));
    chk({tag, ".iter1"}, 32'(it1), 32'(eit));
    chk({tag, ".iter4"}, 32'(it4), 32'(eit));
    chk({tag, ".hit"}, {hit1, hit4}, {ehit, ehit});
    chk({tag, ".black"}, {blk1, blk4}, {eblk, eblk});
    snap1 = {it1, hit1, blk1};
    snap4 = {it4, hit4, blk4};
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_out"}, {snap1, snap4},
          {it1, hit1, blk1, it4, hit4, blk4});
      chk({tag, ".hold_vr"}, {val1, val4, rdy1, rdy4},
          4'b1100);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".post_hs"}, {val1, val4, rdy1, rdy4}, 4'b0011);
  endtask

  initial begin
    logic [23:0] rgb;
    logic [1:0]  m;
    logic [7:0]  mx, eit;
    logic        ehit, eblk;
    int          l1, l4, pick;
    int          mul[4][3];

    vecs[0] = '{24'h328222, 2'd0, 8'd64, 8'd10, 1'b1, 1'b0, 11, 3};
    vecs[1] = '{24'h000000, 2'd0, 8'd64, 8'd0, 1'b1, 1'b1, 1, 1};
    vecs[2] = '{24'h000000, 2'd2, 8'd0, 8'd0, 1'b1, 1'b1, 1, 1};
    vecs[3] = '{24'h010203, 2'd0, 8'd64, 8'd64, 1'b0, 1'b0, 64, 16};
    vecs[4] = '{24'h010203, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1, 1};
    vecs[5] = '{24'h858F4C, 2'd3, 8'd20, 8'd19, 1'b1, 1'b0, 20, 5};
    vecs[6] = '{24'h8CA450, 2'd3, 8'd20, 8'd20, 1'b0, 1'b0, 20, 5};
    vecs[7] = '{24'h5A1EAA, 2'd1, 8'd255, 8'd10, 1'b1, 1'b0, 11, 3};

    mul[0] = '{5, 13, 29};
    mul[1] = '{9, 3, 17};
    mul[2] = '{4, 2, 11};
    mul[3] = '{7, 21, 4};

    #12;
    chk("rst.out", {val1, it1, hit1, blk1, val4, it4, hit4, blk4}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.ready", {rdy1, rdy4}, 2'b11);

    for (int v = 0; v < 8; v++)
      run_req($sformatf("vec%0d", v), vecs[v].rgb, vecs[v].mode,
              vecs[v].mx, vecs[v].it, vecs[v].hit, vecs[v].blk,
              vecs[v].lat1, vecs[v].lat4, (v == 0) ? 5 : 0);

    // Abort mid-search with an asynchronous reset.
    @(negedge clk);
    in_rgb = 24'h010203;
    in_mode = 2'd0;
    in_max_iter = 8'd64;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.state", {val1, val4, rdy1, rdy4}, 4'b0011);
    @(negedge clk);
    rst_n = 1'b1;
    run_req("after_rst", vecs[0].rgb, vecs[0].mode, vecs[0].mx,
            vecs[0].it, vecs[0].hit, vecs[0].blk,
            vecs[0].lat1, vecs[0].lat4, 0);

    for (int n = 0; n < 40; n++) begin
      m = 2'($urandom_range(0, 3));
      mx = 8'($urandom_range(0, 255));
      pick = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0)
        rgb = {8'((pick * mul[m][0]) % 256),
               8'((pick * mul[m][1]) % 256),
               8'((pick * mul[m][2]) % 256)};
      else
        rgb = 24'($urandom);
      model(rgb, m, mx, eit, ehit, eblk, l1, l4);
      run_req($sformatf("rnd%0d", n), rgb, m, mx, eit, ehit, eblk,
              l1, l4, n % 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/palette_decode.md
# palette_decode

Inverse colour mapper: takes a 24-bit RGB888 pixel produced by the explorer's colouring stage and recovers the iteration count that produced it under a given palette mode and max_iter. Used on frame-buffer readback paths such as cursor-pick, histogram and zoom-target selection, where only stored pixels are available. It is a sequential search engine. It evaluates the team palette for `LANES` candidate counts per cycle and uses valid/ready handshakes on both sides.

## Interface
- `LANES`, 1: candidate iteration counts tested per cycle; legal values 1, 2, 4.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request; high only in IDLE.
- `in_rgb`  in  24  pixel {r[23:16], g[15:8], b[7:0]}.
- `in_mode`  in  2  palette mode 0..3.
- `in_max_iter`  in  8  max_iter used when the pixel was coloured.
- `out_valid`  out  1  result valid; held until accepted.
- `out_ready`  in  1  downstream accepts the result.
- `out_iter`  out  8  decoded iteration count; equals the latched max_iter on a miss.
- `out_hit`  out  1  1 = pixel matched a candidate or black.
- `out_black`  out  1  1 = pixel was 0x000000; iteration 0 and inside-set are indistinguishable.

## Operation
- Palette evaluated per candidate i, with all products truncated mod 256:
  - mode 0: r=5i, g=13i, b=29i.
  - mode 1: r=9i, g=3i, b=17i.
  - mode 2: r=i<<2, g=i<<1, b=11i.
  - mode 3: r=7i, g=21i, b=4i.
- Only i < max_iter are candidates. Counts at or above max_iter render black.
- FSM states: IDLE, SEARCH, DONE.
  - IDLE: `in_ready`=1. When `in_valid` is high, latch rgb, mode and max_iter, clear cand to 0, and go to SEARCH.
  - SEARCH, evaluated in priority order each cycle:
    - If latched rgb is 0: DONE with out_iter=0, out_hit=1, out_black=1. This applies even when max_iter=0.
    - Otherwise test candidates cand..cand+LANES-1, skipping any that are ≥ max_iter.
    - On any match: DONE with out_iter = lowest matching candidate, out_hit=1, out_black=0.
    - Otherwise, if cand+LANES ≥ max_iter (including max_iter=0): DONE with out_iter=max_iter, out_hit=0, out_black=0.
    - Otherwise cand += LANES and stay in SEARCH.
  - DONE: `out_valid`=1 and out_* held stable. When `out_ready` is high, go to IDLE.
- Candidate counter is 9 bits, so cand+LANES never wraps past 255.
- Each mode has an odd multiplier on at least one channel, so the map over 0..255 is injective. The lowest-match priority is still required.
- `out_iter`, `out_hit` and `out_black` are registered and change only on entry to DONE.

## Timing
- Reset (async assert; deassert synchronised externally):
  - state=IDLE, cand=0.
  - out_valid=0, out_iter=0, out_hit=0, out_black=0.
  - in_ready=1 once rst_n is high.
- Assertion mid-SEARCH or mid-DONE aborts the request; no result is emitted.
- Accept edge = edge 0. out_valid rises after:
  - edge 1 for black;
  - edge 1+floor(k/LANES) for a hit at k;
  - edge max(1, ceil(max_iter/LANES)) for a miss.
- Worst case with LANES=1: 255 cycles search plus 1 cycle handoff.
- No back-to-back acceptance: in_ready is low from edge 0 until the cycle after the out handshake.
- The out handshake and the next IDLE accept cannot coincide; they are at least one edge apart.
- in_* are ignored outside IDLE.

## Test plan
- **Hit, mode 0:** LANES=1, mode 0, max_iter 64, rgb 0x328222 (i=10) -> out_iter 10, hit 1, black 0; out_valid after edge 11.
- **Black:** any mode, max_iter 64, rgb 0x000000 -> out_iter 0, hit 1, black 1 after edge 1. Repeat with max_iter 0 -> same result.
- **Miss:** LANES=1, mode 0, max_iter 64, rgb 0x010203 -> out_iter 64, hit 0 after edge 64. Repeat with max_iter 0 -> out_iter 0, hit 0 after edge 1.
- **max_iter boundary, mode 3, max_iter 20:**
  - rgb 0x858F4C (i=19) -> out_iter 19, hit 1.
  - rgb 0x8CA450 (i=20) -> out_iter 20, hit 0.
- **Multi-lane hit:** LANES=4, mode 1, max_iter 255, rgb 0x5A1EAA (i=10) -> out_iter 10 after edge 3.
- **Backpressure and reset:**
  - out_ready low for 5 cycles in DONE -> out_* stable and in_ready 0; after the handshake, in_ready is 1 the next cycle.
  - rst_n pulsed low at search cycle 3 -> out_valid 0 and in_ready 1 immediately; a fresh request then decodes correctly.
